// File: rtl/if_stage.sv
// Instruction-fetch stage: req/ack fetch FSM feeding a 2-entry {pc, ins} FIFO.
// Optional perf counters are enabled by defining IF_STAGE_PERF_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP_INS  = 32'hdc000000
) (
  input  logic        clk,
  input  logic        rstd,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] pc_out,
  output logic [31:0] ins_out,
  output logic        valid_out,
  output logic        halted
`ifdef IF_STAGE_PERF_EN
  ,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_dropped
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DROP = 2'd2;
  localparam logic [1:0] HALT = 2'd3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } fent_t;

  logic [1:0]  state, state_n;
  logic [31:0] pc, pc_n, last_pc;
  fent_t [1:0] fifo;
  logic [1:0]  count, count_n, wr_idx;
  logic        flush, pop, push, ack, is_halt;

  assign valid_out = (count != 2'd0);
  assign flush     = redirect && !halted;
  assign pop       = valid_out && !stall && !flush;
  assign ack       = imem_req && imem_ack;
  assign push      = (state == REQ) && ack && !flush;
  assign is_halt   = (imem_rdata[31:26] == 6'b111111);
  assign wr_idx    = count - {1'b0, pop};

  assign pc_out  = valid_out ? fifo[0].pc  : last_pc;
  assign ins_out = valid_out ? fifo[0].ins : NOP_INS;

  always_comb begin
    count_n = count;
    if (flush)              count_n = 2'd0;
    else if (push && !pop)  count_n = count + 2'd1;
    else if (pop && !push)  count_n = count - 2'd1;
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    if (push)  pc_n = pc + 32'd4;
    if (flush) pc_n = redirect_pc;
    case (state)
      IDLE: if (flush || count_n != 2'd2) state_n = REQ;
      REQ: begin
        // ack coinciding with a redirect completes the old beat, so no DROP needed
        if (flush)    state_n = ack ? REQ : DROP;
        else if (ack) state_n = is_halt ? HALT : ((count_n == 2'd2) ? IDLE : REQ);
      end
      DROP: if (ack) state_n = REQ;
      HALT: if (flush) state_n = REQ;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      count     <= 2'd0;
      fifo      <= '0;
      last_pc   <= RESET_PC;
      halted    <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      count    <= count_n;
      imem_req <= (state_n == REQ) || (state_n == DROP);
      // DROP keeps the stale address on the bus until its ack arrives
      if (state_n != DROP) imem_addr <= pc_n;
      if (pop) last_pc <= fifo[0].pc;
      halted <= halted || ((state_n == HALT) && (count_n == 2'd0));
      if (!flush) begin
        if (pop) fifo[0] <= fifo[1];
        if (push) fifo[wr_idx[0]] <= '{pc: pc, ins: imem_rdata};
      end
    end
  end

`ifdef IF_STAGE_PERF_EN
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;

  always_comb begin
    drop_inc = flush ? count : 2'd0;
    if (ack && (state == DROP || (state == REQ && flush))) drop_inc = drop_inc + 2'd1;
    drop_sum = {1'b0, perf_dropped} + {15'd0, drop_inc};
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      perf_fetched <= 16'd0;
      perf_dropped <= 16'd0;
    end else begin
      if (push && perf_fetched != 16'hffff) perf_fetched <= perf_fetched + 16'd1;
      perf_dropped <= drop_sum[16] ? 16'hffff : drop_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: stream, backpressure, redirect, halt, wrap, async reset.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rstd = 1'b0;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic [31:0] pc_out, ins_out;
  logic        valid_out, halted;
`ifdef IF_STAGE_PERF_EN
  logic [15:0] perf_fetched, perf_dropped;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int lat    = 1;
  bit halt_en = 1'b0;
  int mem_cnt = 0;

  localparam logic [31:0] WORD = 32'h20010005;
  localparam logic [31:0] HWRD = 32'hfc000000;
  localparam logic [31:0] NOPW = 32'hdc000000;

  if_stage dut (
    .clk(clk), .rstd(rstd),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .pc_out(pc_out), .ins_out(ins_out), .valid_out(valid_out), .halted(halted)
`ifdef IF_STAGE_PERF_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
  );

  always #5 clk = ~clk;

  // Memory: ack after lat cycles of req; halt word at 0xC when enabled
  assign imem_ack   = imem_req && (mem_cnt == lat - 1);
  assign imem_rdata = (halt_en && imem_addr == 32'hc) ? HWRD : WORD;

  always @(posedge clk or negedge rstd) begin
    if (!rstd)         mem_cnt <= 0;
    else if (imem_ack) mem_cnt <= 0;
    else if (imem_req) mem_cnt <= mem_cnt + 1;
    else               mem_cnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rstd = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rstd = 1'b1;
  endtask

  initial begin
    // reset values and stream
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_ins", ins_out, NOPW);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    rstd = 1'b1;
    step;
    chk("a_req_e1", {31'd0, imem_req}, 32'd1);
    chk("a_addr_e1", imem_addr, 32'h0);
    chk("a_valid_e1", {31'd0, valid_out}, 32'd0);
    step;
    chk("a_valid_e2", {31'd0, valid_out}, 32'd1);
    chk("a_pc_e2", pc_out, 32'h0);
    chk("a_ins_e2", ins_out, WORD);
    for (int k = 1; k <= 3; k++) begin
      step;
      chk("a_stream_pc", pc_out, 32'(4 * k));
      chk("a_stream_valid", {31'd0, valid_out}, 32'd1);
    end

    // backpressure
    do_reset;
    step; step;
    stall = 1'b1;
    step;
    chk("b_req_full", {31'd0, imem_req}, 32'd0);
    chk("b_pc_full", pc_out, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step;
      chk("b_hold_req", {31'd0, imem_req}, 32'd0);
      chk("b_hold_pc", pc_out, 32'h0);
      chk("b_hold_ins", ins_out, WORD);
    end
    stall = 1'b0;
    step;
    chk("b_rel_pc4", pc_out, 32'h4);
    chk("b_rel_req", {31'd0, imem_req}, 32'd1);
    chk("b_rel_addr", imem_addr, 32'h8);
    step;
    chk("b_rel_pc8", pc_out, 32'h8);
    step;
    chk("b_rel_pc12", pc_out, 32'hc);

    // redirect while a 3-cycle fetch at 0x8 is pending
    lat = 3;
    do_reset;
    repeat (7) step;
    chk("c_pc4", pc_out, 32'h4);
    chk("c_addr8", imem_addr, 32'h8);
    step;
    redirect = 1'b1; redirect_pc = 32'h100;
    step;
    redirect = 1'b0;
    chk("c_addr_hold", imem_addr, 32'h8);
    chk("c_req_hold", {31'd0, imem_req}, 32'd1);
    chk("c_valid_flush", {31'd0, valid_out}, 32'd0);
    step;
    chk("c_addr_new", imem_addr, 32'h100);
    chk("c_drop_valid", {31'd0, valid_out}, 32'd0);
    step; step;
    chk("c_wait_valid", {31'd0, valid_out}, 32'd0);
    step;
    chk("c_first_valid", {31'd0, valid_out}, 32'd1);
    chk("c_first_pc", pc_out, 32'h100);

    // halt word at 0xC
    lat = 1; halt_en = 1'b1;
    do_reset;
    repeat (5) step;
    chk("d_halt_pc", pc_out, 32'hc);
    chk("d_halt_ins", ins_out, HWRD);
    chk("d_halt_req", {31'd0, imem_req}, 32'd0);
    chk("d_halted_pre", {31'd0, halted}, 32'd0);
    step;
    chk("d_halted", {31'd0, halted}, 32'd1);
    chk("d_empty_ins", ins_out, NOPW);
    chk("d_empty_pc", pc_out, 32'hc);
    redirect = 1'b1; redirect_pc = 32'h40;
    step;
    redirect = 1'b0;
    chk("d_redir_ign_req", {31'd0, imem_req}, 32'd0);
    chk("d_redir_ign_halt", {31'd0, halted}, 32'd1);
    step;
    chk("d_still_idle", {31'd0, imem_req}, 32'd0);

    // wrong-path halt flushed by redirect
    do_reset;
    repeat (5) step;
    stall = 1'b1;
    step;
    chk("e_held_ins", ins_out, HWRD);
    chk("e_not_halted", {31'd0, halted}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h40;
    step;
    redirect = 1'b0; stall = 1'b0;
    chk("e_flush_valid", {31'd0, valid_out}, 32'd0);
    chk("e_flush_ins", ins_out, NOPW);
    chk("e_req", {31'd0, imem_req}, 32'd1);
    chk("e_addr", imem_addr, 32'h40);
    chk("e_halted", {31'd0, halted}, 32'd0);
    step;
    chk("e_resume_pc", pc_out, 32'h40);
    chk("e_resume_ins", ins_out, WORD);

    // wrap and async reset mid-ack
    halt_en = 1'b0;
    do_reset;
    step;
    redirect = 1'b1; redirect_pc = 32'hfffffffc;
    step;
    redirect = 1'b0;
    chk("f_addr_top", imem_addr, 32'hfffffffc);
    chk("f_discard", {31'd0, valid_out}, 32'd0);
    step;
    chk("f_pc_top", pc_out, 32'hfffffffc);
    chk("f_addr_wrap", imem_addr, 32'h0);
    step;
    chk("f_pc_wrap", pc_out, 32'h0);
    chk("f_ack_live", {31'd0, imem_ack}, 32'd1);
    #2 rstd = 1'b0;
    #1;
    chk("f_arst_req", {31'd0, imem_req}, 32'd0);
    chk("f_arst_addr", imem_addr, 32'h0);
    chk("f_arst_valid", {31'd0, valid_out}, 32'd0);
    chk("f_arst_ins", ins_out, NOPW);
    chk("f_arst_pc", pc_out, 32'h0);
    chk("f_arst_halted", {31'd0, halted}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
